// File: rtl/full_st0_tap_arb.sv
// Arbitrates one single-port tap memory between a forward reader and an error-update requester.
// Zero-cycle grant; read data returns one cycle after a read grant; update is forced after STARVE_MAX denials.
module full_st0_tap_arb #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 192,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_fwd_req,
  input  logic [ADDR_W-1:0] i_fwd_addr,
  output logic              o_fwd_gnt,
  input  logic              i_upd_req,
  input  logic              i_upd_wr,
  input  logic [ADDR_W-1:0] i_upd_addr,
  input  logic [DATA_W-1:0] i_upd_wr_data,
  output logic              o_upd_gnt,
  output logic              o_mem_en,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wr_data,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  output logic              o_rd_vld,
  output logic              o_rd_src,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_starved
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_rd_vld;
  logic             r_rd_src;

  logic w_at_max;
  logic w_fwd_gnt;
  logic w_upd_gnt;
  logic w_starved;

  assign w_at_max = (r_starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    w_fwd_gnt = 1'b0;
    w_upd_gnt = 1'b0;
    w_starved = 1'b0;
    if (!i_reset) begin
      // Forward owns the port unless the update side has waited STARVE_MAX cycles.
      w_upd_gnt = i_upd_req && (!i_fwd_req || w_at_max);
      w_fwd_gnt = i_fwd_req && !w_upd_gnt;
      w_starved = i_fwd_req && i_upd_req && w_at_max;
    end
  end

  always_comb begin
    o_fwd_gnt     = w_fwd_gnt;
    o_upd_gnt     = w_upd_gnt;
    o_starved     = w_starved;
    o_mem_en      = w_fwd_gnt || w_upd_gnt;
    o_mem_wr      = w_upd_gnt && i_upd_wr;
    o_mem_addr    = '0;
    o_mem_wr_data = '0;
    if (w_upd_gnt) begin
      o_mem_addr = i_upd_addr;
    end else if (w_fwd_gnt) begin
      o_mem_addr = i_fwd_addr;
    end
    if (!i_reset) begin
      o_mem_wr_data = i_upd_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
      r_rd_vld     <= 1'b0;
      r_rd_src     <= 1'b0;
    end else begin
      if (i_upd_req && !w_upd_gnt) begin
        r_starve_cnt <= w_at_max ? r_starve_cnt : r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end
      r_rd_vld <= w_fwd_gnt || (w_upd_gnt && !i_upd_wr);
      r_rd_src <= w_upd_gnt;
    end
  end

  // Read return is masked by reset so a grant in the prior cycle never surfaces.
  assign o_rd_vld  = r_rd_vld && !i_reset;
  assign o_rd_src  = r_rd_src && r_rd_vld && !i_reset;
  assign o_rd_data = (r_rd_vld && !i_reset) ? i_mem_rd_data : '0;

endmodule
